data_memory_unit: RTL and testbench

//  Data memory stage of the RV32I single-cycle core. Consumes the ALU result as the byte

---
 rtl/data_memory_unit_pkg.sv | 15 +
 rtl/data_memory_unit_store_lane_gen.sv | 45 ++++
 rtl/data_memory_unit.sv | 84 ++++++++
 tb/tb_data_memory_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/data_memory_unit_pkg.sv
// Shared funct3 encodings for the RV32I data memory stage.
// Store and load widths share encodings, so the load names alias the store names.
package data_memory_unit_pkg;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/data_memory_unit_store_lane_gen.sv
// Turns a store's funct3, byte offset and rs2 value into byte-lane enables and lane-placed data.
// Flags misaligned or illegal stores so that the top can drop the write.
module store_lane_gen
    import data_memory_unit_pkg::*;
(
    input  logic [2:0]  iFunct3,
    input  logic [1:0]  iOff,
    input  logic [31:0] iWrData,
    output logic [3:0]  wBE,
    output logic [31:0] wLaneData,
    output logic        wBad
);

    always_comb begin
        wBE       = 4'b0000;
        wLaneData = 32'h0000_0000;
        wBad      = 1'b0;
        case (iFunct3)
            F3_SB: begin
                wBE       = 4'b0001 << iOff;
                wLaneData = {4{iWrData[7:0]}};
            end
            F3_SH: begin
                if (iOff[0]) begin
                    wBad = 1'b1;
                end else begin
                    wBE = iOff[1] ? 4'b1100 : 4'b0011;
                end
                wLaneData = {2{iWrData[15:0]}};
            end
            F3_SW: begin
                if (iOff != 2'b00) begin
                    wBad = 1'b1;
                end else begin
                    wBE = 4'b1111;
                end
                wLaneData = iWrData;
            end
            default: begin
                wBad = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_unit.sv
// Data memory stage of the single-cycle RV32I core: byte-lane stores on the clock edge,
// combinational sign/zero-extended loads, and a sticky flag for the last rejected store.
module data_memory_unit
    import data_memory_unit_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iData_WrEn,
    input  logic [2:0]  iFunct3,
    input  logic [31:0] iAddr,
    input  logic [31:0] iWrData,
    output logic [31:0] oRdData,
    output logic        oMisalign
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wIdx;
    logic [1:0]        wOff;
    logic [3:0]        wBE;
    logic [31:0]       wLaneData;
    logic              wBad;
    logic [31:0]       wWord;
    logic [7:0]        rdByte;
    logic [15:0]       rdHalf;
    logic              unusedAddrBits;

    // Upper address bits are deliberately ignored so the memory aliases modulo DEPTH*4.
    assign wIdx           = iAddr[ADDR_W+1:2];
    assign wOff           = iAddr[1:0];
    assign unusedAddrBits = ^iAddr[31:ADDR_W+2];

    store_lane_gen uLaneGen (
        .iFunct3   (iFunct3),
        .iOff      (wOff),
        .iWrData   (iWrData),
        .wBE       (wBE),
        .wLaneData (wLaneData),
        .wBad      (wBad)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'h0000_0000;
            end
        end else if (iData_WrEn && !wBad) begin
            for (int b = 0; b < 4; b++) begin
                if (wBE[b]) begin
                    mem[wIdx][8*b +: 8] <= wLaneData[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oMisalign <= 1'b0;
        end else if (iData_WrEn) begin
            oMisalign <= wBad;
        end
    end

    // Loads never flag misalignment: halves look only at off[1], words ignore the offset.
    assign wWord  = mem[wIdx];
    assign rdByte = wWord[{wOff, 3'b000} +: 8];
    assign rdHalf = wOff[1] ? wWord[31:16] : wWord[15:0];

    always_comb begin
        oRdData = wWord;
        case (iFunct3)
            F3_LB:   oRdData = {{24{rdByte[7]}}, rdByte};
            F3_LBU:  oRdData = {24'h000000, rdByte};
            F3_LH:   oRdData = {{16{rdHalf[15]}}, rdHalf};
            F3_LHU:  oRdData = {16'h0000, rdHalf};
            F3_LW:   oRdData = wWord;
            default: oRdData = wWord;
        endcase
    end

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit: expected values are queued as stimulus is driven
// and popped against the DUT outputs shortly after each drive or clock edge.
module tb_data_memory_unit;

    logic        iClk;
    logic        iRst_n;
    logic        iData_WrEn;
    logic [2:0]  iFunct3;
    logic [31:0] iAddr;
    logic [31:0] iWrData;
    logic [31:0] oRdData;
    logic        oMisalign;

    typedef struct {
        string       tag;
        bit          isFlag;
        logic [31:0] value;
    } expT;

    expT sbQ[$];
    int  errors = 0;
    int  checks = 0;

    data_memory_unit #(.DEPTH(64)) dut (
        .iClk       (iClk),
        .iRst_n     (iRst_n),
        .iData_WrEn (iData_WrEn),
        .iFunct3    (iFunct3),
        .iAddr      (iAddr),
        .iWrData    (iWrData),
        .oRdData    (oRdData),
        .oMisalign  (oMisalign)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic pushRd(input string tag, input logic [31:0] value);
        expT e;
        e.tag = tag; e.isFlag = 1'b0; e.value = value;
        sbQ.push_back(e);
    endtask

    task automatic pushMis(input string tag, input logic value);
        expT e;
        e.tag = tag; e.isFlag = 1'b1; e.value = {31'b0, value};
        sbQ.push_back(e);
    endtask

    // Drains every queued expectation against the current DUT outputs.
    task automatic checkOutput();
        expT         e;
        logic [31:0] obs;
        while (sbQ.size() > 0) begin
            e   = sbQ.pop_front();
            obs = e.isFlag ? {31'b0, oMisalign} : oRdData;
            checks++;
            assert (obs === e.value) else begin
                errors++;
                $error("[TB] FAIL %s observed=%08h expected=%08h", e.tag, obs, e.value);
            end
        end
    endtask

    // Presents a store just after a falling edge and returns just after the committing rising edge.
    task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] data);
        @(negedge iClk);
        iData_WrEn = 1'b1;
        iFunct3    = f3;
        iAddr      = addr;
        iWrData    = data;
        @(posedge iClk);
        #1;
        iData_WrEn = 1'b0;
    endtask

    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] exp);
        @(negedge iClk);
        iData_WrEn = 1'b0;
        iFunct3    = f3;
        iAddr      = addr;
        pushRd(tag, exp);
        #1;
        checkOutput();
    endtask

    task automatic expectMis(input string tag, input logic exp);
        pushMis(tag, exp);
        checkOutput();
    endtask

    initial begin
        iRst_n     = 1'b0;
        iData_WrEn = 1'b0;
        iFunct3    = 3'b010;
        iAddr      = 32'h0;
        iWrData    = 32'h0;
        repeat (2) @(negedge iClk);
        iRst_n = 1'b1;

        // Reset state.
        load("resetLw", 3'b010, 32'h0000_0024, 32'h0000_0000);
        expectMis("resetMis", 1'b0);

        // Word store and extended loads.
        applyStimulus(3'b010, 32'h10, 32'hDEAD_BEEF);
        expectMis("swAlignedMis", 1'b0);
        load("lw10", 3'b010, 32'h10, 32'hDEAD_BEEF);
        load("lb13", 3'b000, 32'h13, 32'hFFFF_FFDE);
        load("lbu12", 3'b100, 32'h12, 32'h0000_00AD);
        load("lhu12", 3'b101, 32'h12, 32'h0000_DEAD);
        load("lb10pos", 3'b000, 32'h10, 32'hFFFF_FFEF);
        load("rawF3_011", 3'b011, 32'h13, 32'hDEAD_BEEF);

        // Byte and half stores keep the other lanes.
        applyStimulus(3'b010, 32'h10, 32'h1122_3344);
        applyStimulus(3'b000, 32'h11, 32'h0000_005A);
        load("sbMerge", 3'b010, 32'h10, 32'h1122_5A44);
        applyStimulus(3'b001, 32'h12, 32'h0000_8001);
        load("shMerge", 3'b010, 32'h10, 32'h8001_5A44);
        load("lh12", 3'b001, 32'h12, 32'hFFFF_8001);
        load("lh13IgnoresOff0", 3'b001, 32'h13, 32'hFFFF_8001);
        load("lb11Pos", 3'b000, 32'h11, 32'h0000_005A);

        // Misaligned stores are dropped and flagged; the flag holds without a store.
        applyStimulus(3'b010, 32'h21, 32'hCAFE_F00D);
        expectMis("swMisaligned", 1'b1);
        load("swDropped", 3'b010, 32'h20, 32'h0000_0000);
        expectMis("misHoldsOnLoad", 1'b1);
        applyStimulus(3'b001, 32'h23, 32'h0000_1234);
        expectMis("shMisaligned", 1'b1);
        load("shDropped", 3'b010, 32'h20, 32'h0000_0000);
        applyStimulus(3'b010, 32'h20, 32'hCAFE_F00D);
        expectMis("swClearsMis", 1'b0);
        load("swAfterMis", 3'b010, 32'h20, 32'hCAFE_F00D);

        // Illegal funct3 and address aliasing.
        applyStimulus(3'b011, 32'h30, 32'hFFFF_FFFF);
        expectMis("illegalF3", 1'b1);
        load("illegalDropped", 3'b010, 32'h30, 32'h0000_0000);
        applyStimulus(3'b010, 32'h100, 32'h1234_5678);
        expectMis("aliasStoreMis", 1'b0);
        load("alias0", 3'b010, 32'h000, 32'h1234_5678);

        // Read during write shows old contents before the edge, new after it.
        @(negedge iClk);
        iData_WrEn = 1'b1;
        iFunct3    = 3'b010;
        iAddr      = 32'h40;
        iWrData    = 32'hA5A5_0F0F;
        #1;
        pushRd("rdwBefore", 32'h0000_0000);
        checkOutput();
        @(posedge iClk);
        #1;
        pushRd("rdwAfter", 32'hA5A5_0F0F);
        checkOutput();
        iData_WrEn = 1'b0;

        // Back-to-back byte stores to one word merge.
        applyStimulus(3'b000, 32'h44, 32'h0000_00AA);
        applyStimulus(3'b000, 32'h45, 32'h0000_00BB);
        load("b2bMerge", 3'b010, 32'h44, 32'h0000_BBAA);

        // Asynchronous reset mid-cycle with a store pending.
        applyStimulus(3'b111, 32'h00, 32'h0);
        expectMis("misBeforeReset", 1'b1);
        @(negedge iClk);
        iData_WrEn = 1'b1;
        iFunct3    = 3'b010;
        iAddr      = 32'h50;
        iWrData    = 32'h7777_7777;
        #2;
        iRst_n = 1'b0;
        #1;
        pushRd("resetImmediate", 32'h0000_0000);
        pushMis("resetMisImmediate", 1'b0);
        checkOutput();
        @(posedge iClk);
        #1;
        pushRd("storeDuringReset", 32'h0000_0000);
        checkOutput();
        @(negedge iClk);
        iData_WrEn = 1'b0;
        iRst_n     = 1'b1;
        load("resetCleared10", 3'b010, 32'h10, 32'h0000_0000);
        load("resetCleared00", 3'b010, 32'h00, 32'h0000_0000);
        load("resetCleared50", 3'b010, 32'h50, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
